// File: rtl/stream_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : stream_pkt_arbiter
// Description : Merges N_SOURCES valid/ready packet streams into one output
//               stream. Arbitration is round-robin at packet granularity:
//               once a source is granted it keeps the output until its last
//               beat has been accepted. The output is one register stage.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_pkt_arbiter #(
  parameter int T_DATA_WIDTH = 8,
  parameter int N_SOURCES    = 4,
  parameter int ID_WIDTH     = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [0:N_SOURCES-1],
  input  logic [N_SOURCES-1:0]    s_last_i,
  input  logic [N_SOURCES-1:0]    s_valid_i,
  output logic [N_SOURCES-1:0]    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [ID_WIDTH-1:0]     m_id_o,
  output logic                    busy_o
);

  // Candidate index carries one spare bit so rr_ptr + offset cannot overflow
  // before the explicit wrap back into 0..N_SOURCES-1.
  localparam int                CAND_WIDTH = ID_WIDTH + 1;
  localparam logic [CAND_WIDTH-1:0] N_SRC_W = CAND_WIDTH'(N_SOURCES);
  localparam logic [ID_WIDTH-1:0]   LAST_ID = ID_WIDTH'(N_SOURCES - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [T_DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                    m_last_q, m_last_d;
  logic                    m_valid_q, m_valid_d;
  logic [ID_WIDTH-1:0]     m_id_q, m_id_d;

  logic                    pick_found;
  logic [ID_WIDTH-1:0]     pick_id;
  logic [CAND_WIDTH-1:0]   cand;
  logic                    grant_ready;
  logic                    accept;

  // Round-robin search: first valid source at or above rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = 0; i < N_SOURCES; i++) begin
      cand = {1'b0, rr_ptr_q} + CAND_WIDTH'(i);
      if (cand >= N_SRC_W) begin
        cand = cand - N_SRC_W;
      end
      if (!pick_found && s_valid_i[cand[ID_WIDTH-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = cand[ID_WIDTH-1:0];
      end
    end
  end

  // Grant FSM: next state, grant/pointer updates and per-source ready.
  // Ready never looks at s_valid_i, only at the grant and the output stage.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    s_ready_o   = '0;
    grant_ready = 1'b0;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_id;
          state_d    = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        grant_ready            = ~m_valid_q | m_ready_i;
        s_ready_o[grant_id_q]  = grant_ready;
        accept                 = grant_ready & s_valid_i[grant_id_q];
        if (accept && s_last_i[grant_id_q]) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output register: load on every accepted beat, drain when downstream takes it.
  always_comb begin
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_id_d    = m_id_q;
    m_valid_d = m_valid_q;
    if (accept) begin
      m_data_d  = s_data_i[grant_id_q];
      m_last_d  = s_last_i[grant_id_q];
      m_id_d    = grant_id_q;
      m_valid_d = 1'b1;
    end else if (m_ready_i) begin
      m_valid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      m_valid_q  <= 1'b0;
      m_id_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      m_valid_q  <= m_valid_d;
      m_id_q     <= m_id_d;
    end
  end

  assign m_data_o  = m_data_q;
  assign m_last_o  = m_last_q;
  assign m_valid_o = m_valid_q;
  assign m_id_o    = m_id_q;
  assign busy_o    = (state_q == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_stream_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_pkt_arbiter
// Description : Directed self-checking bench for stream_pkt_arbiter with a
//               4-source instance and a 3-source instance (wrap check).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_pkt_arbiter;

  logic       clk;
  logic       rst;

  // 4-source instance
  logic [7:0] s_data [0:3];
  logic [3:0] s_last;
  logic [3:0] s_valid;
  logic [3:0] s_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_valid;
  logic       m_ready;
  logic [1:0] m_id;
  logic       busy;

  // 3-source instance
  logic [7:0] p_data [0:2];
  logic [2:0] p_last;
  logic [2:0] p_valid;
  logic [2:0] p_ready;
  logic [7:0] q_data;
  logic       q_last;
  logic       q_valid;
  logic       q_ready;
  logic [1:0] q_id;
  logic       q_busy;

  int n_total;
  int n_bad;

  // Source model memories and output log
  logic [8:0] mem [4][16];
  int         wr [4];
  int         rd [4];
  bit         gap [4];
  logic [7:0] lg_d [64];
  logic       lg_l [64];
  logic [1:0] lg_id [64];
  int         lg_c [64];
  int         on;
  int         cyc;

  stream_pkt_arbiter #(.T_DATA_WIDTH(8), .N_SOURCES(4)) dut (
    .clk(clk), .rst(rst),
    .s_data_i(s_data), .s_last_i(s_last), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .m_data_o(m_data), .m_last_o(m_last), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_id_o(m_id), .busy_o(busy)
  );

  stream_pkt_arbiter #(.T_DATA_WIDTH(8), .N_SOURCES(3)) dut3 (
    .clk(clk), .rst(rst),
    .s_data_i(p_data), .s_last_i(p_last), .s_valid_i(p_valid), .s_ready_o(p_ready),
    .m_data_o(q_data), .m_last_o(q_last), .m_valid_o(q_valid), .m_ready_i(q_ready),
    .m_id_o(q_id), .busy_o(q_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int s, input logic [7:0] d, input logic l);
    mem[s][wr[s]] = {l, d};
    wr[s]++;
  endtask

  // One cycle of the source model: present head beats, log output transfers.
  task automatic step();
    logic [3:0] fire;
    for (int s = 0; s < 4; s++) begin
      if (rd[s] < wr[s] && !gap[s]) begin
        s_valid[s] = 1'b1;
        s_data[s]  = mem[s][rd[s]][7:0];
        s_last[s]  = mem[s][rd[s]][8];
      end else begin
        s_valid[s] = 1'b0;
        s_data[s]  = 8'h00;
        s_last[s]  = 1'b0;
      end
    end
    #3;
    fire = s_valid & s_ready;
    if (m_valid && m_ready && on < 64) begin
      lg_d[on]  = m_data;
      lg_l[on]  = m_last;
      lg_id[on] = m_id;
      lg_c[on]  = cyc;
      on++;
    end
    tick();
    for (int s = 0; s < 4; s++) begin
      if (fire[s]) rd[s]++;
    end
    cyc++;
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && on < n; i++) step();
    check_val(tag, on, n);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    m_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      wr[s] = 0; rd[s] = 0; gap[s] = 1'b0;
    end
    step();
    step();
    rst = 1'b0;
    on  = 0;
    cyc = 0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    on      = 0;
    cyc     = 0;
    rst     = 1'b1;
    m_ready = 1'b1;
    s_valid = '0;
    s_last  = '0;
    for (int s = 0; s < 4; s++) begin
      s_data[s] = 8'h00; wr[s] = 0; rd[s] = 0; gap[s] = 1'b0;
    end
    p_valid = '0;
    p_last  = '0;
    q_ready = 1'b1;
    for (int s = 0; s < 3; s++) p_data[s] = 8'h00;

    // Reset state
    do_reset();
    check_val("rst_valid", m_valid, 0);
    check_val("rst_last", m_last, 0);
    check_val("rst_data", m_data, 0);
    check_val("rst_id", m_id, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ready", s_ready, 0);

    // Single source, three beats, with cycle-exact latency
    push(2, 8'hA1, 0); push(2, 8'hA2, 0); push(2, 8'hA3, 1);
    step();
    check_val("t1_c1_busy", busy, 1);
    check_val("t1_c1_ready", s_ready, 4'b0100);
    check_val("t1_c1_valid", m_valid, 0);
    step();
    check_val("t1_c2_valid", m_valid, 1);
    check_val("t1_c2_data", m_data, 8'hA1);
    check_val("t1_c2_id", m_id, 2);
    check_val("t1_c2_last", m_last, 0);
    step();
    check_val("t1_c3_data", m_data, 8'hA2);
    check_val("t1_c3_last", m_last, 0);
    step();
    check_val("t1_c4_data", m_data, 8'hA3);
    check_val("t1_c4_last", m_last, 1);
    check_val("t1_c4_busy", busy, 0);
    check_val("t1_c4_ready", s_ready, 0);
    step();
    check_val("t1_c5_valid", m_valid, 0);

    // Pointer now at 3: with sources 0 and 3 pending, 3 goes first
    on = 0;
    push(0, 8'hB0, 1); push(3, 8'hB3, 1);
    run_until("t1b_cnt", 2, 20);
    check_val("t1b_id0", lg_id[0], 3);
    check_val("t1b_d0", lg_d[0], 8'hB3);
    check_val("t1b_id1", lg_id[1], 0);
    check_val("t1b_d1", lg_d[1], 8'hB0);

    // All sources busy, 2-beat packets: order 0,1,2,3,0 with one idle cycle between
    do_reset();
    for (int s = 0; s < 4; s++) begin
      push(s, 8'(s * 16 + 1), 0);
      push(s, 8'(s * 16 + 2), 1);
    end
    push(0, 8'h05, 0); push(0, 8'h06, 1);
    run_until("t2_cnt", 10, 40);
    for (int k = 0; k < 10; k++) begin
      logic [7:0] ed;
      logic [1:0] eid;
      ed  = (k < 8) ? 8'((k / 2) * 16 + 1 + (k % 2)) : 8'(5 + (k % 2));
      eid = (k < 8) ? 2'(k / 2) : 2'd0;
      check_val($sformatf("t2_d%0d", k), lg_d[k], ed);
      check_val($sformatf("t2_id%0d", k), lg_id[k], eid);
      check_val($sformatf("t2_l%0d", k), lg_l[k], k % 2);
      check_val($sformatf("t2_c%0d", k), lg_c[k], 2 + 3 * (k / 2) + (k % 2));
    end

    // Backpressure for 5 cycles mid-packet
    do_reset();
    push(1, 8'hC1, 0); push(1, 8'hC2, 0); push(1, 8'hC3, 0); push(1, 8'hC4, 1);
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      m_ready = 1'b0;
      #1;
      check_val($sformatf("t3_hold_d%0d", i), m_data, 8'hC2);
      check_val($sformatf("t3_hold_v%0d", i), m_valid, 1);
      check_val($sformatf("t3_hold_r%0d", i), s_ready, 0);
      step();
    end
    m_ready = 1'b1;
    run_until("t3_cnt", 4, 20);
    step(); step(); step();
    check_val("t3_cnt_final", on, 4);
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("t3_d%0d", k), lg_d[k], 8'(8'hC1 + k));
      check_val($sformatf("t3_id%0d", k), lg_id[k], 1);
      check_val($sformatf("t3_l%0d", k), lg_l[k], (k == 3) ? 1 : 0);
    end

    // Granted source gaps for 3 cycles while source 0 waits
    do_reset();
    push(1, 8'hE1, 0); push(1, 8'hE2, 0); push(1, 8'hE3, 1);
    step(); step();
    gap[1] = 1'b1;
    push(0, 8'hF1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val($sformatf("t4_gap_busy%0d", i), busy, 1);
      check_val($sformatf("t4_gap_rdy%0d", i), s_ready, 4'b0010);
    end
    gap[1] = 1'b0;
    run_until("t4_cnt", 4, 20);
    check_val("t4_d0", lg_d[0], 8'hE1);
    check_val("t4_d1", lg_d[1], 8'hE2);
    check_val("t4_d2", lg_d[2], 8'hE3);
    check_val("t4_id2", lg_id[2], 1);
    check_val("t4_d3", lg_d[3], 8'hF1);
    check_val("t4_id3", lg_id[3], 0);

    // Reset during beat 2 of a 4-beat packet (pointer was 1 before)
    on = 0;
    push(1, 8'h11, 0); push(1, 8'h12, 0); push(1, 8'h13, 0); push(1, 8'h14, 1);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("t5_valid", m_valid, 0);
    check_val("t5_busy", busy, 0);
    check_val("t5_ready", s_ready, 0);
    rd[1] = wr[1];
    on = 0;
    step();
    check_val("t5_nolast", m_valid, 0);
    push(0, 8'h70, 1); push(3, 8'h73, 1);
    run_until("t5_cnt", 2, 20);
    check_val("t5_id0", lg_id[0], 0);
    check_val("t5_d0", lg_d[0], 8'h70);
    check_val("t5_id1", lg_id[1], 3);
    check_val("t5_d1", lg_d[1], 8'h73);
    check_val("t5_l1", lg_l[1], 1);

    // Three sources: pointer wraps from 2 to 0
    do_reset();
    p_valid = 3'b100; p_data[2] = 8'h33; p_last = 3'b100;
    tick();
    check_val("t6_c1_busy", q_busy, 1);
    check_val("t6_c1_ready", p_ready, 3'b100);
    p_valid = 3'b101; p_data[0] = 8'h30; p_last = 3'b101;
    tick();
    p_data[2] = 8'h32;
    check_val("t6_c2_data", q_data, 8'h33);
    check_val("t6_c2_id", q_id, 2);
    check_val("t6_c2_busy", q_busy, 0);
    tick();
    check_val("t6_c3_ready", p_ready, 3'b001);
    tick();
    p_valid = 3'b100;
    check_val("t6_c4_data", q_data, 8'h30);
    check_val("t6_c4_id", q_id, 0);
    tick();
    check_val("t6_c5_ready", p_ready, 3'b100);
    tick();
    p_valid = 3'b000;
    check_val("t6_c6_data", q_data, 8'h32);
    check_val("t6_c6_id", q_id, 2);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_pkt_arbiter.md
STREAM_PKT_ARBITER -- requirements
Module: stream_pkt_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- T_DATA_WIDTH, 8, beat width.
- N_SOURCES, 4, number of input streams, >=2.
- ID_WIDTH is derived as max(1, $clog2(N_SOURCES)).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, reset; synchronous, active-high.
- s_data_i, in, T_DATA_WIDTH x [0:N_SOURCES-1], per-source data.
- s_last_i, in, N_SOURCES, per-source end-of-packet.
- s_valid_i, in, N_SOURCES, per-source valid.
- s_ready_o, out, N_SOURCES, per-source ready.
- m_data_o, out, T_DATA_WIDTH, arbitrated data.
- m_last_o, out, 1, end-of-packet.
- m_valid_o, out, 1, output valid.
- m_ready_i, in, 1, downstream ready; downstream is typically stream_upsize.
- m_id_o, out, ID_WIDTH, source index of the current output beat.
- busy_o, out, 1, high while a packet is locked.

Function
REQ-003 The block SHALL merge N_SOURCES AXI-Stream-like inputs into one output with packet-granular round-robin arbitration. A beat transfers on any interface when valid & ready are both high at a clk edge.
REQ-004 The FSM SHALL have two states:
- IDLE: no grant.
- LOCKED: grant held by grant_id (ID_WIDTH register).
REQ-005 In IDLE with any s_valid_i high, the block SHALL select the first requester found scanning upward from rr_ptr, wrapping at N_SOURCES-1 -> 0. It SHALL load grant_id and go to LOCKED on the next edge.
REQ-006 In IDLE, s_ready_o SHALL be all zeros. There is one arbitration cycle per packet.
REQ-007 In LOCKED:
- s_ready_o[grant_id] = ~m_valid_o | m_ready_i.
- All other s_ready_o bits SHALL be 0.
REQ-008 The output SHALL be a single register stage (m_data_o, m_last_o, m_id_o, m_valid_o). It loads on every accepted input beat.
REQ-009 The register stage SHALL clear m_valid_o when m_ready_i is high and no new beat loads in the same cycle.
REQ-010 Output signals SHALL stay stable while m_valid_o=1 and m_ready_i=0.
REQ-011 Latency SHALL be as follows:
- Valid in IDLE at cycle N -> s_ready_o high at N+1 -> beat on output at N+2.
- Within a packet: 1 beat per cycle with no bubbles while m_ready_i=1.
REQ-012 On an accepted beat with s_last_i[grant_id]=1, the block SHALL:
- go to IDLE;
- set rr_ptr <= (grant_id+1) mod N_SOURCES, with explicit wrap when N_SOURCES is not a power of two.
REQ-013 A single-beat packet (last on first beat) SHALL occupy LOCKED for exactly one accepted beat.
REQ-014 While LOCKED, the grant SHALL hold regardless of the granted source deasserting valid (gaps allowed, no timeout). Other sources' valid SHALL be ignored.
REQ-015 Re-arbitration in IDLE SHALL proceed even while the output register still holds the previous packet's last beat. The new packet's first beat waits on ready per REQ-007.
REQ-016 s_ready_o SHALL depend combinationally only on state, grant_id, m_valid_o and m_ready_i, never on s_valid_i.
REQ-017 busy_o SHALL be 1 exactly when the state is LOCKED.
REQ-018 The block SHALL NOT drop, duplicate or reorder beats. Beats of one packet SHALL be contiguous on the output with constant m_id_o.

Reset
REQ-019 With rst=1 at a clk edge, the block SHALL set:
- state = IDLE, rr_ptr = 0, grant_id = 0;
- m_valid_o = 0, m_last_o = 0, m_data_o = 0, m_id_o = 0;
- s_ready_o = 0, busy_o = 0.
REQ-020 A reset mid-packet SHALL discard the partial packet and any held output beat. No terminating last beat is generated.
REQ-021 Outputs SHALL be defined from the first edge with rst=1. rst SHALL have no asynchronous effect.

Verification
REQ-022 Single source: N_SOURCES=4, source 2 sends 3 beats (0xA1, 0xA2, 0xA3 last), m_ready_i=1. Required:
- m_valid_o at cycles 2,3,4 with data 0xA1..0xA3;
- m_id_o=2;
- m_last_o only on 0xA3;
- rr_ptr=3 after.
REQ-023 All four sources valid continuously with 2-beat packets. Required:
- grant order 0,1,2,3,0;
- one idle input cycle between packets;
- m_id_o never changes mid-packet.
REQ-024 Backpressure: m_ready_i=0 for 5 cycles mid-packet. Required:
- m_data_o held stable;
- s_ready_o[grant]=0 while m_valid_o=1;
- no beat lost or duplicated after release.
REQ-025 Source 1 is locked, drops valid for 3 cycles mid-packet, and source 0 is valid throughout. Required:
- grant stays 1;
- source 0 is served only after source 1's last beat.
REQ-026 Assert rst during beat 2 of a 4-beat packet. Required:
- next cycle: m_valid_o=0, busy_o=0, rr_ptr=0;
- the next request from source 3 is granted normally.
REQ-027 N_SOURCES=3, source 2 sends a single-beat packet, then sources 0 and 2 request. Required: rr_ptr wraps to 0 and source 0 is granted first.
